// File: rtl/neuron_datapath.sv
// neuron_datapath
//   Shared fixed-point neuron execution unit fed by the datapath router.
//   Accepts one instruction per launch and runs it against an internal
//   signed accumulator: clear, multiply-accumulate (bit-serial signed
//   shift-add, one multiplier bit per cycle) or activation (ReLU or
//   saturate after removing FRAC fractional bits).
//
// Ports
//   clock        in   system clock, all state on rising edge
//   reset        in   synchronous, active-high
//   instruction  in   op word {op[3:0], reserved, A[OPND_W-1:0], B[OPND_W-1:0]}
//   start        in   request; an op launches only on a rising start while idle
//   result       out  op result, stable while finished=1
//   finished     out  1 = idle / result valid, 0 = op in flight
//   busy         out  inverse of finished
//   illegal_op   out  sticky flag: an undefined opcode was executed since reset

module neuron_datapath #(
  parameter int INSTR_W  = 32,
  parameter int RESULT_W = 16,
  parameter int OPND_W   = 12,
  parameter int ACC_W    = 32,
  parameter int FRAC     = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [INSTR_W-1:0]  instruction,
  input  logic                start,
  output logic [RESULT_W-1:0] result,
  output logic                finished,
  output logic                busy,
  output logic                illegal_op
);

  localparam int PROD_W = 2 * OPND_W;
  localparam int CNT_W  = $clog2(OPND_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OPND_W - 1);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_CLR  = 4'd1;
  localparam logic [3:0] OP_MAC  = 4'd3;
  localparam logic [3:0] OP_RELU = 4'd4;
  localparam logic [3:0] OP_SAT  = 4'd5;

  localparam logic signed [ACC_W-1:0] R_MAX = ACC_W'((2 ** (RESULT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] R_MIN = ~R_MAX;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  // Activation: drop FRAC fraction bits, then clamp into the result range.
  // With relu set, negative values collapse to zero instead of the minimum.
  function automatic logic [RESULT_W-1:0] activate(
    input logic signed [ACC_W-1:0] acc,
    input logic                    relu
  );
    logic signed [ACC_W-1:0] r;
    r = acc >>> FRAC;
    if (r > R_MAX)             return R_MAX[RESULT_W-1:0];
    else if (relu && r < 0)    return '0;
    else if (r < R_MIN)        return R_MIN[RESULT_W-1:0];
    else                       return r[RESULT_W-1:0];
  endfunction

  state_t                     state_q, state_d;
  logic                       start_q, start_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [RESULT_W-1:0]        result_q, result_d;
  logic                       finished_q, finished_d;
  logic                       illegal_q, illegal_d;

  logic [3:0]                 op_q, op_d;
  logic signed [PROD_W-1:0]   mcand_q, mcand_d;
  logic [OPND_W-1:0]          mplier_q, mplier_d;
  logic signed [PROD_W-1:0]   prod_q, prod_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  logic [3:0]                 op_fld;
  logic signed [OPND_W-1:0]   a_fld;
  logic [OPND_W-1:0]          b_fld;
  logic                       launch;
  logic                       unused_rsvd;

  assign op_fld      = instruction[INSTR_W-1 -: 4];
  assign a_fld       = instruction[2*OPND_W-1 -: OPND_W];
  assign b_fld       = instruction[OPND_W-1:0];
  assign unused_rsvd = ^instruction[INSTR_W-5:2*OPND_W];

  // Only a rising start seen while idle launches; a held start or a
  // request arriving mid-op is dropped, never queued.
  assign launch = start & ~start_q & (state_q == IDLE);

  always_comb begin
    state_d    = state_q;
    start_d    = start;
    acc_d      = acc_q;
    result_d   = result_q;
    finished_d = finished_q;
    illegal_d  = illegal_q;
    op_d       = op_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    prod_d     = prod_q;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE: begin
        if (launch) begin
          op_d       = op_fld;
          mcand_d    = PROD_W'(a_fld);
          mplier_d   = b_fld;
          prod_d     = '0;
          cnt_d      = '0;
          finished_d = 1'b0;
          state_d    = (op_fld == OP_MAC) ? MUL : EXEC;
        end
      end

      EXEC: begin
        case (op_q)
          OP_NOP:  ;
          OP_CLR: begin
            acc_d    = '0;
            result_d = '0;
          end
          OP_RELU: result_d  = activate(acc_q, 1'b1);
          OP_SAT:  result_d  = activate(acc_q, 1'b0);
          default: illegal_d = 1'b1;
        endcase
        finished_d = 1'b1;
        state_d    = IDLE;
      end

      // Two's complement multiplier: the top bit of B carries negative
      // weight, so its partial product is subtracted rather than added.
      MUL: begin
        if (mplier_q[0]) begin
          if (cnt_q == CNT_LAST) prod_d = prod_q - mcand_q;
          else                   prod_d = prod_q + mcand_q;
        end
        mcand_d  = {mcand_q[PROD_W-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[OPND_W-1:1]};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = DONE;
      end

      DONE: begin
        acc_d      = acc_q + ACC_W'(prod_q);
        finished_d = 1'b1;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Control and architectural state
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      acc_q      <= '0;
      result_q   <= '0;
      finished_q <= 1'b1;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      finished_q <= finished_d;
      illegal_q  <= illegal_d;
    end
  end

  // Operand / multiplier working registers (always written before use)
  always_ff @(posedge clock) begin
    op_q     <= op_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    prod_q   <= prod_d;
    cnt_q    <= cnt_d;
  end

  assign result     = result_q;
  assign finished   = finished_q;
  assign busy       = ~finished_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_neuron_datapath.sv
// tb_neuron_datapath
//   Directed-vector bench for neuron_datapath. Each op is launched with a
//   start pulse; latency (edges from launch to finished=1), result, flags and
//   the internal accumulator are compared against hand-computed values.

module tb_neuron_datapath;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_CLR  = 4'd1;
  localparam logic [3:0] OP_MAC  = 4'd3;
  localparam logic [3:0] OP_RELU = 4'd4;
  localparam logic [3:0] OP_SAT  = 4'd5;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        start;
  logic [15:0] result;
  logic        finished;
  logic        busy;
  logic        illegal_op;

  int n_vec = 0;
  int n_bad = 0;
  int lat;

  neuron_datapath dut (
    .clock       (clock),
    .reset       (reset),
    .instruction (instruction),
    .start       (start),
    .result      (result),
    .finished    (finished),
    .busy        (busy),
    .illegal_op  (illegal_op)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Launch one op. hold=2 keeps start high over two edges; poke raises a
  // fresh start carrying a CLR word mid-flight, which must be ignored.
  task automatic run_op(input logic [3:0] op, input logic [11:0] a, input logic [11:0] b,
                        input int hold, input bit poke, output int k);
    instruction = {op, 4'h0, a, b};
    start       = 1'b1;
    @(posedge clock); #1;
    check_eq("busy_after_launch", {31'b0, busy}, 32'd1);
    if (hold < 2) start = 1'b0;
    k = 0;
    while (!finished && k < 40) begin
      if (poke && k == 4) begin
        instruction = {OP_CLR, 28'h0};
        start       = 1'b1;
      end
      @(posedge clock); #1;
      k++;
      start = 1'b0;
    end
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    instruction = '0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_result",   {16'b0, result},       32'h0);
    check_eq("rst_finished", {31'b0, finished},     32'd1);
    check_eq("rst_busy",     {31'b0, busy},         32'd0);
    check_eq("rst_illegal",  {31'b0, illegal_op},   32'd0);
    reset = 1'b0;

    // 1: 0x100 * 0x200 = 0x20000, >>>8 = 0x200
    run_op(OP_CLR, 12'h0, 12'h0, 1, 0, lat);
    check_eq("t1_clr_lat", lat, 1);
    run_op(OP_MAC, 12'h100, 12'h200, 1, 0, lat);
    check_eq("t1_mac_lat", lat, 13);
    check_eq("t1_mac_res", {16'b0, result}, 32'h0);
    run_op(OP_SAT, 12'h0, 12'h0, 1, 0, lat);
    check_eq("t1_sat_lat", lat, 1);
    check_eq("t1_sat_res", {16'b0, result}, 32'h0200);

    // 2: 4 * 2047^2 = 16760836, >>>8 = 65472 -> saturates
    run_op(OP_CLR, 12'h0, 12'h0, 1, 0, lat);
    for (int i = 0; i < 4; i++) run_op(OP_MAC, 12'h7FF, 12'h7FF, 1, 0, lat);
    check_eq("t2_acc", dut.acc_q, 32'd16760836);
    run_op(OP_SAT, 12'h0, 12'h0, 1, 0, lat);
    check_eq("t2_sat_res", {16'b0, result}, 32'h7FFF);
    run_op(OP_RELU, 12'h0, 12'h0, 1, 0, lat);
    check_eq("t2_relu_res", {16'b0, result}, 32'h7FFF);

    // 3: -2048 * 1 = -2048, >>>8 = -8
    run_op(OP_CLR, 12'h0, 12'h0, 1, 0, lat);
    run_op(OP_MAC, 12'h800, 12'h001, 1, 0, lat);
    run_op(OP_RELU, 12'h0, 12'h0, 1, 0, lat);
    check_eq("t3_relu_res", {16'b0, result}, 32'h0000);
    run_op(OP_SAT, 12'h0, 12'h0, 1, 0, lat);
    check_eq("t3_sat_res", {16'b0, result}, 32'hFFF8);
    run_op(OP_NOP, 12'h0, 12'h0, 1, 0, lat);
    check_eq("t3_nop_lat", lat, 1);
    check_eq("t3_nop_res", {16'b0, result}, 32'hFFF8);

    // 4: start held two cycles -> single launch, acc = 0x100
    run_op(OP_CLR, 12'h0, 12'h0, 1, 0, lat);
    run_op(OP_MAC, 12'h100, 12'h001, 2, 0, lat);
    check_eq("t4_mac_lat", lat, 13);
    check_eq("t4_acc", dut.acc_q, 32'd256);
    run_op(OP_SAT, 12'h0, 12'h0, 1, 0, lat);
    check_eq("t4_sat_res", {16'b0, result}, 32'h0001);

    // Corner: -2048 * -2048 = +2^22 exactly; mid-op CLR request is dropped
    run_op(OP_CLR, 12'h0, 12'h0, 1, 0, lat);
    run_op(OP_MAC, 12'h800, 12'h800, 1, 1, lat);
    check_eq("corner_mac_lat", lat, 13);
    check_eq("corner_acc", dut.acc_q, 32'h0040_0000);
    run_op(OP_SAT, 12'h0, 12'h0, 1, 0, lat);
    check_eq("corner_sat_res", {16'b0, result}, 32'h4000);

    // 6: undefined opcode
    run_op(4'hF, 12'h123, 12'h456, 1, 0, lat);
    check_eq("t6_ill_lat", lat, 1);
    check_eq("t6_ill_res", {16'b0, result}, 32'h4000);
    check_eq("t6_ill_flag", {31'b0, illegal_op}, 32'd1);
    check_eq("t6_ill_acc", dut.acc_q, 32'h0040_0000);
    run_op(OP_NOP, 12'h0, 12'h0, 1, 0, lat);
    check_eq("t6_ill_sticky", {31'b0, illegal_op}, 32'd1);

    // 5: reset five cycles into a MAC aborts it
    instruction = {OP_MAC, 4'h0, 12'h005, 12'h003};
    start       = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check_eq("t5_busy_mid", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    check_eq("t5_finished", {31'b0, finished},   32'd1);
    check_eq("t5_result",   {16'b0, result},     32'h0);
    check_eq("t5_acc",      dut.acc_q,           32'h0);
    check_eq("t5_illegal",  {31'b0, illegal_op}, 32'd0);

    // start already high as reset releases -> launches on first edge
    instruction = {OP_SAT, 28'h0};
    start       = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    check_eq("post_rst_launch", {31'b0, busy}, 32'd1);
    start = 1'b0;
    @(posedge clock); #1;
    check_eq("post_rst_done", {31'b0, finished}, 32'd1);
    check_eq("post_rst_res",  {16'b0, result},   32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
